// File: rtl/rect_linear.sv
// rect_linear: registered ReLU activation stage.
// Outputs max(x, 0) after LATENCY clocks, with an optional upper clamp (ReLU-N),
// a matching valid pipeline, and a saturating count of negative input samples.
// Optional feature: define RECT_LINEAR_LEAKY_EN for a leaky ReLU, where negative
// inputs output rect_in >>> LEAK_SHIFT instead of 0.
module rect_linear #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    LATENCY    = 1,
    parameter logic [DATA_WIDTH-1:0] CLAMP_MAX  = '0,
`ifdef RECT_LINEAR_LEAKY_EN
    parameter int                    LEAK_SHIFT = 3,
`endif
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rect_in,
    input  logic                  in_valid,
    input  logic                  clear_count,
    output logic [DATA_WIDTH-1:0] rect_out,
    output logic                  out_valid,
    output logic [CNT_WIDTH-1:0]  neg_count
);

    logic                                is_neg;
    logic [DATA_WIDTH-1:0]               result;
    logic [LATENCY-1:0][DATA_WIDTH-1:0]  data_pipe;
    logic [LATENCY:1]                    vld_pipe;

    assign is_neg = rect_in[DATA_WIDTH-1];

    // Activation function on the raw input; the clamp only ever touches non-negative results.
    always_comb begin
        result = rect_in;
        if (is_neg) begin
`ifdef RECT_LINEAR_LEAKY_EN
            result = $signed(rect_in) >>> LEAK_SHIFT;
`else
            result = '0;
`endif
        end else if (CLAMP_MAX != '0 && rect_in > CLAMP_MAX) begin
            result = CLAMP_MAX;
        end
    end

    // Data and valid shift together every clock; there is no stall, so in-flight data
    // is only ever lost to reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_pipe <= '0;
            vld_pipe  <= '0;
        end else begin
            data_pipe[0] <= result;
            vld_pipe[1]  <= in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                data_pipe[i]  <= data_pipe[i-1];
                vld_pipe[i+1] <= vld_pipe[i];
            end
        end
    end

    assign rect_out  = data_pipe[LATENCY-1];
    assign out_valid = vld_pipe[LATENCY];

    // Negative-sample counter, counted at input time; a clear beats a same-cycle increment.
    always_ff @(posedge clock) begin
        if (reset || clear_count) begin
            neg_count <= '0;
        end else if (in_valid && is_neg && neg_count != '1) begin
            neg_count <= neg_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_rect_linear.sv
// Testbench for rect_linear: two instances share one input stream.
// u0 uses the default configuration; u1 has LATENCY=3, CLAMP_MAX=6 and CNT_WIDTH=4.
module tb_rect_linear;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] rect_in;
    logic        in_valid;
    logic        clear_count;
    logic [31:0] rect_out0, rect_out1;
    logic        out_valid0, out_valid1;
    logic [15:0] neg_count0;
    logic [3:0]  neg_count1;

    int errors = 0;
    int checks = 0;

    // Reference state: input history (index 0 = sampled at the latest edge) and counters.
    logic [31:0] hd [0:3];
    logic        hv [0:3];
    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    always #5 clock = ~clock;

    rect_linear u0 (
        .clock(clock), .reset(reset), .rect_in(rect_in), .in_valid(in_valid),
        .clear_count(clear_count), .rect_out(rect_out0), .out_valid(out_valid0),
        .neg_count(neg_count0)
    );

    rect_linear #(.DATA_WIDTH(32), .LATENCY(3), .CLAMP_MAX(32'd6), .CNT_WIDTH(4)) u1 (
        .clock(clock), .reset(reset), .rect_in(rect_in), .in_valid(in_valid),
        .clear_count(clear_count), .rect_out(rect_out1), .out_valid(out_valid1),
        .neg_count(neg_count1)
    );

    function automatic logic [31:0] neg_val(input logic [31:0] x);
`ifdef RECT_LINEAR_LEAKY_EN
        return $signed(x) >>> 3;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] f0(input logic [31:0] x);
        return x[31] ? neg_val(x) : x;
    endfunction

    function automatic logic [31:0] f1(input logic [31:0] x);
        if (x[31]) return neg_val(x);
        return (x > 32'd6) ? 32'd6 : x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: update the reference from the inputs sampled at the edge, then check all outputs.
    task automatic tick();
        @(posedge clock);
        if (reset) begin
            for (int i = 0; i < 4; i++) begin hd[i] = '0; hv[i] = 1'b0; end
            cnt0 = '0;
            cnt1 = '0;
        end else begin
            for (int i = 3; i > 0; i--) begin hd[i] = hd[i-1]; hv[i] = hv[i-1]; end
            hd[0] = rect_in;
            hv[0] = in_valid;
            if (clear_count) begin
                cnt0 = '0;
                cnt1 = '0;
            end else if (in_valid && rect_in[31]) begin
                if (cnt0 != '1) cnt0 = cnt0 + 1'b1;
                if (cnt1 != '1) cnt1 = cnt1 + 1'b1;
            end
        end
        #1;
        chk("u0_out",   rect_out0,  f0(hd[0]));
        chk("u0_valid", {31'd0, out_valid0}, {31'd0, hv[0]});
        chk("u0_cnt",   {16'd0, neg_count0}, {16'd0, cnt0});
        chk("u1_out",   rect_out1,  f1(hd[2]));
        chk("u1_valid", {31'd0, out_valid1}, {31'd0, hv[2]});
        chk("u1_cnt",   {28'd0, neg_count1}, {28'd0, cnt1});
    endtask

    task automatic drive(input logic [31:0] d, input logic v);
        rect_in  = d;
        in_valid = v;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin hd[i] = '0; hv[i] = 1'b0; end
        cnt0 = '0;
        cnt1 = '0;
        reset       = 1'b1;
        clear_count = 1'b0;
        rect_in     = 32'h7FFF_FFFF;
        in_valid    = 1'b1;

        // Reset held two cycles with a valid positive input present
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_out",   rect_out0, 32'd0);
            chk("rst_valid", {31'd0, out_valid0}, 32'd0);
            chk("rst_cnt",   {16'd0, neg_count0}, 32'd0);
            chk("rst_valid1", {31'd0, out_valid1}, 32'd0);
        end
        reset = 1'b0;

        // Positive pass-through, one clock latency
        drive(32'd12345, 1'b1);
        chk("pass_out",   rect_out0, 32'd12345);
        chk("pass_valid", {31'd0, out_valid0}, 32'd1);

        // Negative input rectified and counted
        drive(32'hFFFF_FFF6, 1'b1);
`ifdef RECT_LINEAR_LEAKY_EN
        chk("neg_out", rect_out0, 32'hFFFF_FFFE);
`else
        chk("neg_out", rect_out0, 32'd0);
`endif
        chk("neg_cnt", {16'd0, neg_count0}, 32'd1);

        // Clamp on u1 (latency 3): 5, 6, 7, 1000 -> 5, 6, 6, 6
        drive(32'd5, 1'b1);
        drive(32'd6, 1'b1);
        drive(32'd7, 1'b1);
        chk("clamp_5", rect_out1, 32'd5);
        drive(32'd1000, 1'b1);
        chk("clamp_6", rect_out1, 32'd6);
        drive(32'd0, 1'b0);
        chk("clamp_7", rect_out1, 32'd6);
        drive(32'd0, 1'b0);
        chk("clamp_1000", rect_out1, 32'd6);
        chk("clamp_zero_u0", rect_out0, 32'd0);

        // Boundary values
        drive(32'h8000_0000, 1'b1);
`ifdef RECT_LINEAR_LEAKY_EN
        chk("min_neg", rect_out0, 32'hF000_0000);
`else
        chk("min_neg", rect_out0, 32'd0);
`endif
        drive(32'h7FFF_FFFF, 1'b1);
        chk("max_pos", rect_out0, 32'h7FFF_FFFF);

        // Random stream with boundary values mixed in
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] d;
            d = $urandom;
            if (i % 50 == 0) d = 32'd0;
            else if (i % 50 == 1) d = 32'h8000_0000;
            else if (i % 50 == 2) d = 32'h7FFF_FFFF;
            drive(d, 1'($urandom_range(0, 1)));
        end

        // Counter saturation and clear priority
        reset = 1'b1;
        drive(32'd0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) drive(32'hFFFF_FFFF - 32'(i), 1'b1);
        chk("sat_cnt1", {28'd0, neg_count1}, 32'd15);
        chk("cnt0_20",  {16'd0, neg_count0}, 32'd20);
        clear_count = 1'b1;
        drive(32'hFFFF_FF00, 1'b1);
        clear_count = 1'b0;
        chk("clr_cnt0", {16'd0, neg_count0}, 32'd0);
        chk("clr_cnt1", {28'd0, neg_count1}, 32'd0);

        // Mid-stream reset drops in-flight samples
        drive(32'd100, 1'b1);
        drive(32'd200, 1'b1);
        reset = 1'b1;
        drive(32'd300, 1'b1);
        reset = 1'b0;
        chk("mrst_valid0", {31'd0, out_valid0}, 32'd0);
        chk("mrst_out0",   rect_out0, 32'd0);
        chk("mrst_valid1", {31'd0, out_valid1}, 32'd0);
        drive(32'd400, 1'b1);
        chk("post_out0",   rect_out0, 32'd400);
        chk("post_valid0", {31'd0, out_valid0}, 32'd1);
        chk("post_valid1", {31'd0, out_valid1}, 32'd0);
        drive(32'd0, 1'b0);
        chk("post_drop1",  {31'd0, out_valid1}, 32'd0);
        drive(32'd0, 1'b0);
        chk("post_out1",   rect_out1, 32'd6);
        chk("post_vld1",   {31'd0, out_valid1}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
